// File: rtl/axil_slave_mem_if.sv
// AXI4-Lite bus bundle for axil_slave_mem: the five channels (AW, W, B, AR, R)
// with master and slave views. Clock and reset are not carried here.
interface axil_slave_mem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_slave_mem.sv
// axil_slave_mem: AXI4-Lite slave backed by a word-addressed register memory.
// Independent write (AW/W -> B) and read (AR -> R) state machines; addresses
// outside BASE_ADDR .. BASE_ADDR+4*DEPTH-1 complete with SLVERR.
// Optional feature: define AXIL_SLV_WSTRB_EN to honour WSTRB byte lanes;
// without it every in-range write replaces the whole word.
module axil_slave_mem #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0C00
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    axil_slave_mem_if.slave s
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EXT_W  = ADDR_WIDTH + 1;

    // Window bounds carry one extra bit so the top of the window cannot wrap.
    localparam logic [EXT_W-1:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [EXT_W-1:0] WIN_HI = WIN_LO + EXT_W'(4 * DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [EXT_W-1:0] a_ext;
        a_ext = {1'b0, addr};
        return (a_ext >= WIN_LO) && (a_ext < WIN_HI);
    endfunction

    // Word index inside the window; the two byte-offset bits are dropped.
    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    w_state_t              w_state_q;
    logic                  awready_q;
    logic                  wready_q;
    logic                  aw_got_q;
    logic                  w_got_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
`ifdef AXIL_SLV_WSTRB_EN
    logic [STRB_W-1:0]     wstrb_q;
`endif
    logic                  bvalid_q;
    logic [1:0]            bresp_q;

    r_state_t              r_state_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    // Write FSM: latch AW and W independently, commit one edge after both are held, then hold B until accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
`ifdef AXIL_SLV_WSTRB_EN
            wstrb_q   <= '0;
`endif
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_got_q && w_got_q) begin
                        if (addr_in_range(awaddr_q)) begin
`ifdef AXIL_SLV_WSTRB_EN
                            for (int b = 0; b < STRB_W; b++) begin
                                if (wstrb_q[b]) begin
                                    mem_q[addr_index(awaddr_q)][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                end
                            end
`else
                            mem_q[addr_index(awaddr_q)] <= wdata_q;
`endif
                            bresp_q <= RESP_OKAY;
                        end else begin
                            bresp_q <= RESP_SLVERR;
                        end
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end else begin
                        if (awready_q && s.AWVALID) begin
                            awaddr_q  <= s.AWADDR;
                            aw_got_q  <= 1'b1;
                            awready_q <= 1'b0;
                        end else if (!aw_got_q) begin
                            awready_q <= 1'b1;
                        end
                        if (wready_q && s.WVALID) begin
                            wdata_q  <= s.WDATA;
`ifdef AXIL_SLV_WSTRB_EN
                            wstrb_q  <= s.WSTRB;
`endif
                            w_got_q  <= 1'b1;
                            wready_q <= 1'b0;
                        end else if (!w_got_q) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s.BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: sample memory on the AR handshake (pre-write data on a same-edge commit), hold R until accepted.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && s.ARVALID) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                        if (addr_in_range(s.ARADDR)) begin
                            rdata_q <= mem_q[addr_index(s.ARADDR)];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s.AWREADY = awready_q;
    assign s.WREADY  = wready_q;
    assign s.BVALID  = bvalid_q;
    assign s.BRESP   = bresp_q;
    assign s.ARREADY = arready_q;
    assign s.RVALID  = rvalid_q;
    assign s.RDATA   = rdata_q;
    assign s.RRESP   = rresp_q;
endmodule

// File: tb/tb_axil_slave_mem.sv
// Self-checking bench for axil_slave_mem: directed scenarios plus randomized
// traffic compared against an array model of the address window.
module tb_axil_slave_mem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [256];

    axil_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_slave_mem dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .s       (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Window is 0xC00 .. 0xC00 + 4*256 - 1, evaluated without 32-bit wrap.
    function automatic bit model_hit(input logic [31:0] a);
        longint unsigned la;
        la = 64'(a);
        return (la >= 64'h0C00) && (la < 64'h0C00 + 64'd1024);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a - 32'h0C00) / 32'd4);
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
        if (model_hit(a)) begin
`ifdef AXIL_SLV_WSTRB_EN
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[model_idx(a)][b*8 +: 8] = d[b*8 +: 8];
            end
`else
            model_mem[model_idx(a)] = d;
`endif
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    endfunction

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                               input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0;
        bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = strb;
        while (!(aw_done && w_done) && cyc < 60) begin
            @(negedge clk);
            bus.AWVALID = !aw_done && (cyc >= aw_dly);
            bus.WVALID  = !w_done && (cyc >= w_dly);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge clk);
            if (aw_hs) aw_done = 1'b1;
            if (w_hs) w_done = 1'b1;
            cyc++;
        end
        checks++;
        if (!(aw_done && w_done)) begin
            failures++;
            $display("FAIL aw_w_handshake: aw_done=%0d w_done=%0d required both 1", aw_done, w_done);
        end
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b0) begin
            failures++;
            $display("FAIL b_early: BVALID=%b required 0 one cycle after capture", bus.BVALID);
        end
    endtask

    task automatic wait_bresp(input int b_dly, input logic [1:0] exp_resp);
        @(negedge clk);
        checks++;
        if (bus.BVALID !== 1'b1) begin
            failures++;
            $display("FAIL b_latency: BVALID=%b required 1", bus.BVALID);
        end
        for (int k = 0; k < b_dly; k++) begin
            checks++;
            if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0) begin
                failures++;
                $display("FAIL b_hold: cyc=%0d BVALID=%b BRESP=%b AWREADY=%b WREADY=%b required 1 %b 0 0",
                         k, bus.BVALID, bus.BRESP, bus.AWREADY, bus.WREADY, exp_resp);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.BVALID !== 1'b1 || bus.BRESP !== exp_resp) begin
            failures++;
            $display("FAIL bresp: BVALID=%b BRESP=%b required 1 %b", bus.BVALID, bus.BRESP, exp_resp);
        end
        bus.BREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.BREADY = 1'b0;
        checks++;
        if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1) begin
            failures++;
            $display("FAIL b_release: BVALID=%b AWREADY=%b WREADY=%b required 0 1 1",
                     bus.BVALID, bus.AWREADY, bus.WREADY);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] exp_resp;
        exp_resp = model_hit(a) ? 2'b00 : 2'b10;
        issue_write(a, d, strb, aw_dly, w_dly);
        wait_bresp(b_dly, exp_resp);
        model_write(a, d, strb);
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int cyc;
        bit done, hs;
        cyc = 0; done = 1'b0;
        bus.ARADDR = a;
        while (!done && cyc < 60) begin
            @(negedge clk);
            bus.ARVALID = (cyc >= ar_dly);
            hs = bus.ARVALID && bus.ARREADY;
            @(posedge clk);
            if (hs) done = 1'b1;
            cyc++;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL ar_handshake: no AR handshake for addr %h", a);
        end
        @(negedge clk);
        bus.ARVALID = 1'b0;
        checks++;
        if (bus.RVALID !== 1'b1) begin
            failures++;
            $display("FAIL r_latency: RVALID=%b required 1", bus.RVALID);
        end
        for (int k = 0; k < r_dly; k++) begin
            checks++;
            if (bus.RVALID !== 1'b1 || bus.RDATA !== exp_data || bus.RRESP !== exp_resp || bus.ARREADY !== 1'b0) begin
                failures++;
                $display("FAIL r_hold: cyc=%0d RVALID=%b RDATA=%h RRESP=%b ARREADY=%b required 1 %h %b 0",
                         k, bus.RVALID, bus.RDATA, bus.RRESP, bus.ARREADY, exp_data, exp_resp);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.RDATA !== exp_data || bus.RRESP !== exp_resp) begin
            failures++;
            $display("FAIL rdata: addr=%h RDATA=%h RRESP=%b required %h %b",
                     a, bus.RDATA, bus.RRESP, exp_data, exp_resp);
        end
        bus.RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.RREADY = 1'b0;
        checks++;
        if (bus.RVALID !== 1'b0 || bus.ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL r_release: RVALID=%b ARREADY=%b required 0 1", bus.RVALID, bus.ARREADY);
        end
    endtask

    task automatic read_model(input logic [31:0] a, input int ar_dly, input int r_dly);
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        exp_data = model_hit(a) ? model_mem[model_idx(a)] : 32'h0;
        exp_resp = model_hit(a) ? 2'b00 : 2'b10;
        do_read(a, ar_dly, r_dly, exp_data, exp_resp);
    endtask

    task automatic test_reset();
        bus.AWADDR = 32'h0; bus.AWVALID = 1'b0; bus.WDATA = 32'h0; bus.WSTRB = 4'h0;
        bus.WVALID = 1'b0; bus.BREADY = 1'b0; bus.ARADDR = 32'h0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;
        rst_n = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0 || bus.ARREADY !== 1'b0 ||
            bus.BVALID !== 1'b0 || bus.RVALID !== 1'b0 || bus.BRESP !== 2'b00 ||
            bus.RRESP !== 2'b00 || bus.RDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: AWR=%b WR=%b ARR=%b BV=%b RV=%b BRESP=%b RRESP=%b RDATA=%h required all 0",
                     bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                     bus.BRESP, bus.RRESP, bus.RDATA);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.AWREADY !== 1'b0 || bus.ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: AWREADY=%b ARREADY=%b required 0 0", bus.AWREADY, bus.ARREADY);
        end
        @(negedge clk);
        checks++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1 || bus.ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge: AWREADY=%b WREADY=%b ARREADY=%b required 1 1 1",
                     bus.AWREADY, bus.WREADY, bus.ARREADY);
        end
    endtask

    task automatic test_basic();
        do_write(32'h0000_0C00, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        read_model(32'h0000_0C00, 0, 0);
        checks++;
        if (model_mem[0] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL model_basic: model word0=%h required deadbeef", model_mem[0]);
        end
    endtask

    task automatic test_w_before_aw();
        do_write(32'h0000_0FFC, 32'h0000_1234, 4'hF, 2, 0, 0);
        read_model(32'h0000_0FFC, 0, 0);
        do_write(32'h0000_0C10, 32'hCAFE_0001, 4'hF, 0, 3, 1);
        read_model(32'h0000_0C10, 1, 0);
    endtask

    task automatic test_out_of_range();
        do_write(32'h0000_05FF, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        read_model(32'h0000_0BFC, 0, 0);
        read_model(32'h0000_1000, 0, 0);
        read_model(32'hFFFF_FFFC, 0, 0);
        do_write(32'h0000_1000, 32'h7777_7777, 4'hF, 1, 0, 0);
        read_model(32'h0000_0C00, 0, 0);
        read_model(32'h0000_0FFF, 0, 0);
    endtask

    task automatic test_backpressure();
        do_write(32'h0000_0C20, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
        read_model(32'h0000_0C20, 0, 5);
    endtask

    task automatic test_wstrb();
        logic [31:0] exp_word;
`ifdef AXIL_SLV_WSTRB_EN
        exp_word = 32'h1122_CCDD;
`else
        exp_word = 32'hAABB_CCDD;
`endif
        do_write(32'h0000_0C04, 32'h1122_3344, 4'hF, 0, 0, 0);
        do_write(32'h0000_0C04, 32'hAABB_CCDD, 4'h3, 0, 0, 0);
        do_read(32'h0000_0C04, 0, 0, exp_word, 2'b00);
        do_write(32'h0000_0C04, 32'h0F0F_0F0F, 4'h0, 0, 0, 0);
        read_model(32'h0000_0C04, 0, 0);
    endtask

    task automatic test_simul_rw();
        logic [31:0] pre;
        do_write(32'h0000_0C08, 32'h0101_0101, 4'hF, 0, 0, 0);
        pre = model_mem[2];
        fork
            begin
                issue_write(32'h0000_0C08, 32'h0202_0202, 4'hF, 0, 0);
                wait_bresp(0, 2'b00);
            end
            begin
                do_read(32'h0000_0C08, 1, 0, pre, 2'b00);
            end
        join
        model_write(32'h0000_0C08, 32'h0202_0202, 4'hF);
        read_model(32'h0000_0C08, 0, 0);
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [31:0] edges [6];
        edges[0] = 32'h0000_0BFC; edges[1] = 32'h0000_0C00; edges[2] = 32'h0000_0FFC;
        edges[3] = 32'h0000_1000; edges[4] = 32'hFFFF_FFFC; edges[5] = 32'h0000_0BFF;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'h0000_0C00 + (32'($urandom_range(0, 255)) << 2) + 32'($urandom_range(0, 3));
                2:    a = edges[$urandom_range(0, 5)];
                default: a = $urandom;
            endcase
            d = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3));
            end else begin
                read_model(a, $urandom_range(0, 2), $urandom_range(0, 3));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_write(32'h0000_0C00, 32'h1357_9BDF, 4'hF, 0, 0, 0);
        issue_write(32'h0000_0C00, 32'h55AA_55AA, 4'hF, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.BVALID !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: BVALID=%b required 1", bus.BVALID);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.BVALID !== 1'b0 || bus.AWREADY !== 1'b0 || bus.ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: BVALID=%b AWREADY=%b ARREADY=%b required 0 0 0",
                     bus.BVALID, bus.AWREADY, bus.ARREADY);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.AWREADY !== 1'b1 || bus.WREADY !== 1'b1 || bus.ARREADY !== 1'b1 || bus.BVALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_ready: AWREADY=%b WREADY=%b ARREADY=%b BVALID=%b required 1 1 1 0",
                     bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID);
        end
        do_read(32'h0000_0C00, 0, 0, 32'h0, 2'b00);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_wstrb();
        test_simul_rw();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
